timer_request_scheduler: RTL



---
 rtl/timer_request_scheduler_pkg.sv | 56 +++++
 rtl/timer_request_scheduler_if.sv | 30 +++
 rtl/timer_request_scheduler_rr_arbiter.sv | 35 +++
 rtl/timer_request_scheduler.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/timer_request_scheduler_pkg.sv
// Shared definitions for the timer request scheduler.
// Covers the timer register map, the control word bits, the scheduler states and the bus command helpers.
package timer_sched_pkg;

  localparam int TMR_ADDR_W = 3;
  localparam int TMR_DATA_W = 16;

  localparam logic [TMR_ADDR_W-1:0] ADDR_STATUS   = 3'd0;
  localparam logic [TMR_ADDR_W-1:0] ADDR_CONTROL  = 3'd1;
  localparam logic [TMR_ADDR_W-1:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [TMR_ADDR_W-1:0] ADDR_PERIOD_H = 3'd3;
  localparam logic [TMR_ADDR_W-1:0] ADDR_SNAP_L   = 3'd4;
  localparam logic [TMR_ADDR_W-1:0] ADDR_SNAP_H   = 3'd5;

  localparam logic [TMR_DATA_W-1:0] CTL_ITO   = 16'h0001;
  localparam logic [TMR_DATA_W-1:0] CTL_CONT  = 16'h0002;
  localparam logic [TMR_DATA_W-1:0] CTL_START = 16'h0004;
  localparam logic [TMR_DATA_W-1:0] CTL_STOP  = 16'h0008;

  // One-shot timeout: interrupt enabled and started, never continuous.
  localparam logic [TMR_DATA_W-1:0] CTL_ONESHOT = (CTL_ITO | CTL_START) & ~CTL_CONT;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_PL,
    ST_WR_PH,
    ST_WR_CTL,
    ST_WAIT,
    ST_CLR_ST,
    ST_STOP,
    ST_SNAP,
    ST_RD_L,
    ST_RD_H,
    ST_CAP_H,
    ST_FIN
  } sched_state_t;

  typedef struct packed {
    logic                  cs;
    logic                  write_n;
    logic [TMR_ADDR_W-1:0] addr;
    logic [TMR_DATA_W-1:0] data;
  } bus_cmd_t;

  localparam bus_cmd_t BUS_IDLE = '{cs: 1'b0, write_n: 1'b1, addr: '0, data: '0};

  function automatic bus_cmd_t bus_write(input logic [TMR_ADDR_W-1:0] addr,
                                         input logic [TMR_DATA_W-1:0] data);
    bus_write = '{cs: 1'b1, write_n: 1'b0, addr: addr, data: data};
  endfunction

  function automatic bus_cmd_t bus_read(input logic [TMR_ADDR_W-1:0] addr);
    bus_read = '{cs: 1'b1, write_n: 1'b1, addr: addr, data: '0};
  endfunction

endpackage

// File: rtl/timer_request_scheduler_if.sv
// Register port of the shared interval timer: the scheduler drives it as master, the timer answers as slave.
interface timer_request_scheduler_if;
  import timer_sched_pkg::*;

  logic [TMR_ADDR_W-1:0] tmr_address;
  logic                  tmr_chipselect;
  logic                  tmr_write_n;
  logic [TMR_DATA_W-1:0] tmr_writedata;
  logic [TMR_DATA_W-1:0] tmr_readdata;
  logic                  tmr_irq;

  modport master (
    output tmr_address,
    output tmr_chipselect,
    output tmr_write_n,
    output tmr_writedata,
    input  tmr_readdata,
    input  tmr_irq
  );

  modport slave (
    input  tmr_address,
    input  tmr_chipselect,
    input  tmr_write_n,
    input  tmr_writedata,
    output tmr_readdata,
    output tmr_irq
  );

endinterface

// File: rtl/timer_request_scheduler_rr_arbiter.sv
// Combinational round-robin pick: returns the first asserted request at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   pointer,
  output logic               valid,
  output logic [IDX_W-1:0]   index
);

  logic [IDX_W:0]   sum_idx [NUM_REQ];
  logic [IDX_W-1:0] rot_idx [NUM_REQ];
  logic [NUM_REQ-1:0] rot_req;

  // Offset gi from the pointer maps back to an absolute index; pointer < NUM_REQ so one subtract wraps.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rotate
    assign sum_idx[gi] = {1'b0, pointer} + (IDX_W+1)'(gi);
    assign rot_idx[gi] = (sum_idx[gi] >= (IDX_W+1)'(NUM_REQ))
                         ? IDX_W'(sum_idx[gi] - (IDX_W+1)'(NUM_REQ))
                         : IDX_W'(sum_idx[gi]);
    assign rot_req[gi] = req[rot_idx[gi]];
  end

  always_comb begin
    valid = |req;
    index = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot_req[i]) begin
        index = rot_idx[i];
      end
    end
  end

endmodule

// File: rtl/timer_request_scheduler.sv
// Shares one interval timer among NUM_REQ one-shot timeout requesters.
// Grants round-robin, programs the timer, waits for irq or cancel and returns done to the owner.
module timer_request_scheduler
  import timer_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [32*NUM_REQ-1:0]   req_delay,
  input  logic [NUM_REQ-1:0]      cancel,
  output logic [NUM_REQ-1:0]      done,
  output logic                    done_cancelled,
  output logic [31:0]             remaining,
  output logic                    busy,
  output logic [IDX_W-1:0]        owner,
  timer_request_scheduler_if.master tmr
);

  sched_state_t state_reg, state_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [IDX_W-1:0]   owner_reg, owner_next;
  logic [31:0]        delay_reg, delay_next;
  logic               cancelled_reg, cancelled_next;
  logic [15:0]        snap_lo_reg, snap_lo_next;
  logic [31:0]        remaining_reg, remaining_next;
  logic [NUM_REQ-1:0] done_reg, done_next;
  logic               done_cancelled_reg, done_cancelled_next;
  logic               busy_reg, busy_next;
  bus_cmd_t           bus_reg, bus_next;

  logic               arb_valid;
  logic [IDX_W-1:0]   arb_index;
  logic [31:0]        delay_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_delay
    assign delay_arr[gi] = req_delay[32*gi +: 32];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req     (req),
    .pointer (ptr_reg),
    .valid   (arb_valid),
    .index   (arb_index)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg          <= ST_IDLE;
      ptr_reg            <= '0;
      owner_reg          <= '0;
      delay_reg          <= '0;
      cancelled_reg      <= 1'b0;
      snap_lo_reg        <= '0;
      remaining_reg      <= '0;
      done_reg           <= '0;
      done_cancelled_reg <= 1'b0;
      busy_reg           <= 1'b0;
      bus_reg            <= BUS_IDLE;
    end else begin
      state_reg          <= state_next;
      ptr_reg            <= ptr_next;
      owner_reg          <= owner_next;
      delay_reg          <= delay_next;
      cancelled_reg      <= cancelled_next;
      snap_lo_reg        <= snap_lo_next;
      remaining_reg      <= remaining_next;
      done_reg           <= done_next;
      done_cancelled_reg <= done_cancelled_next;
      busy_reg           <= busy_next;
      bus_reg            <= bus_next;
    end
  end

  always_comb begin
    state_next          = state_reg;
    ptr_next            = ptr_reg;
    owner_next          = owner_reg;
    delay_next          = delay_reg;
    cancelled_next      = cancelled_reg;
    snap_lo_next        = snap_lo_reg;
    remaining_next      = remaining_reg;

    case (state_reg)
      ST_IDLE: begin
        if (arb_valid) begin
          state_next = ST_WR_PL;
          owner_next = arb_index;
          delay_next = delay_arr[arb_index];
        end
      end
      ST_WR_PL:  state_next = ST_WR_PH;
      ST_WR_PH:  state_next = ST_WR_CTL;
      ST_WR_CTL: state_next = ST_WAIT;
      ST_WAIT: begin
        // A coincident irq takes priority: the timeout already expired.
        if (tmr.tmr_irq) begin
          state_next = ST_CLR_ST;
        end else if (cancel[owner_reg]) begin
          state_next = ST_STOP;
        end
      end
      ST_CLR_ST: state_next = ST_FIN;
      ST_STOP:   state_next = ST_SNAP;
      ST_SNAP:   state_next = ST_RD_L;
      ST_RD_L:   state_next = ST_RD_H;
      ST_RD_H: begin
        snap_lo_next = tmr.tmr_readdata;
        state_next   = ST_CAP_H;
      end
      ST_CAP_H: begin
        remaining_next = {tmr.tmr_readdata, snap_lo_reg};
        cancelled_next = 1'b1;
        state_next     = ST_CLR_ST;
      end
      ST_FIN: begin
        ptr_next       = (owner_reg == IDX_W'(NUM_REQ - 1)) ? '0 : owner_reg + 1'b1;
        cancelled_next = 1'b0;
        state_next     = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every registered output lines up with its state.
  always_comb begin
    bus_next            = BUS_IDLE;
    done_next           = '0;
    done_cancelled_next = 1'b0;
    busy_next           = (state_next != ST_IDLE);

    case (state_next)
      ST_WR_PL:  bus_next = bus_write(ADDR_PERIOD_L, delay_next[15:0]);
      ST_WR_PH:  bus_next = bus_write(ADDR_PERIOD_H, delay_next[31:16]);
      ST_WR_CTL: bus_next = bus_write(ADDR_CONTROL, CTL_ONESHOT);
      ST_CLR_ST: bus_next = bus_write(ADDR_STATUS, 16'h0000);
      ST_STOP:   bus_next = bus_write(ADDR_CONTROL, CTL_STOP);
      ST_SNAP:   bus_next = bus_write(ADDR_SNAP_L, 16'h0000);
      ST_RD_L:   bus_next = bus_read(ADDR_SNAP_L);
      ST_RD_H:   bus_next = bus_read(ADDR_SNAP_H);
      ST_FIN: begin
        done_next           = NUM_REQ'(1) << owner_reg;
        done_cancelled_next = cancelled_reg;
      end
      default: bus_next = BUS_IDLE;
    endcase
  end

  assign done               = done_reg;
  assign done_cancelled     = done_cancelled_reg;
  assign remaining          = remaining_reg;
  assign busy               = busy_reg;
  assign owner              = owner_reg;
  assign tmr.tmr_address    = bus_reg.addr;
  assign tmr.tmr_chipselect = bus_reg.cs;
  assign tmr.tmr_write_n    = bus_reg.write_n;
  assign tmr.tmr_writedata  = bus_reg.data;

endmodule
